// File: rtl/dmem_ctrl.sv
// Data-memory stage controller: word-organised byte-addressable RAM with fixed
// access latency, pipeline stall, and aligned, sign/zero-extended load return.
module dmem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall,
  output logic              done,
  output logic              err
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                store_q, store_d;
  logic                conflict_q, conflict_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem_q [WORDS];

  logic                bad;
  logic                commit;
  logic                wrEn;
  logic [3:0]          be;
  logic [DATA_W-1:0]   laneData;
  logic [DATA_W-1:0]   memWord;
  logic [7:0]          byteSel;
  logic [15:0]         halfSel;
  logic [DATA_W-1:0]   loadVal;

  // Misalignment or a size code that the captured op cannot use.
  always_comb begin
    bad = 1'b0;
    case (funct3_q)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr_q[0];
      3'b010:  bad = (addr_q[1:0] != 2'b00);
      3'b100:  bad = store_q;
      3'b101:  bad = store_q | addr_q[0];
      default: bad = 1'b1;
    endcase
  end

  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);
  assign wrEn   = commit && store_q && !bad && reset;

  always_comb begin
    be       = 4'b1111;
    laneData = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be       = 4'b0001 << addr_q[1:0];
        laneData = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        laneData = {2{wdata_q[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        laneData = wdata_q;
      end
    endcase
  end

  assign memWord = mem_q[addr_q[ADDR_W-1:2]];
  assign byteSel = memWord[{addr_q[1:0], 3'b000} +: 8];
  assign halfSel = memWord[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    loadVal = memWord;
    case (funct3_q)
      3'b000:  loadVal = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadVal = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadVal = {24'd0, byteSel};
      3'b101:  loadVal = {16'd0, halfSel};
      default: loadVal = memWord;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    store_d    = store_q;
    conflict_d = conflict_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (rd | wr) begin
          addr_d     = addr;
          funct3_d   = funct3;
          wdata_d    = wr_data;
          store_d    = wr;
          conflict_d = rd & wr;
          cnt_d      = 4'(LAT - 1);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          err_d   = bad | conflict_q;
          if (bad) begin
            rdata_d = '0;
          end else if (!store_q) begin
            rdata_d = loadVal;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      funct3_q   <= 3'b000;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      wdata_q    <= wdata_d;
      store_q    <= store_d;
      conflict_q <= conflict_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // RAM is never cleared; an access aborted by reset never reaches this write.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          mem_q[addr_q[ADDR_W-1:2]][8*k +: 8] <= laneData[8*k +: 8];
        end
      end
    end
  end

  assign stall   = ((state_q == IDLE) && (rd | wr)) || (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign err     = (state_q == DONE) && err_q;
  assign rd_data = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, reset-abort
// sequence, then randomized accesses against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [8:0]  addr;
  logic [2:0]  funct3;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        stall;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  refMem [512];
  logic [31:0] refRd;

  typedef struct {
    logic        rdI;
    logic        wrI;
    logic [8:0]  addrI;
    logic [2:0]  f3I;
    logic [31:0] wdI;
    logic        expErr;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs[$];

  dmem_ctrl #(.DATA_W(32), .ADDR_W(9), .LAT(LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .funct3  (funct3),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .stall   (stall),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one access and watch it until done, bounded by a cycle budget.
  task automatic applyStimulus(input logic rdI, input logic wrI, input logic [8:0] a,
                               input logic [2:0] f3, input logic [31:0] wd,
                               output logic gotErr, output logic [31:0] gotRd,
                               output int doneCycle, output int stallCycles,
                               output logic strayErr);
    @(negedge clk);
    rd = rdI; wr = wrI; addr = a; funct3 = f3; wr_data = wd;
    stallCycles = 0;
    doneCycle   = -1;
    strayErr    = 1'b0;
    gotErr      = 1'b0;
    gotRd       = 32'h0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall) stallCycles++;
      if (err && !done) strayErr = 1'b1;
      if (done) begin
        doneCycle = c;
        gotErr    = err;
        gotRd     = rd_data;
        break;
      end
      @(negedge clk);
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic rdI, input logic wrI,
                             input logic [8:0] a, input logic [2:0] f3, input logic [31:0] wd,
                             input logic expErr, input logic [31:0] expRd);
    logic gotErr, strayErr;
    logic [31:0] gotRd;
    int doneCycle, stallCycles;
    applyStimulus(rdI, wrI, a, f3, wd, gotErr, gotRd, doneCycle, stallCycles, strayErr);
    checkOutput({tag, " doneCycle"}, 32'(doneCycle), 32'(LAT + 1));
    checkOutput({tag, " stallCycles"}, 32'(stallCycles), 32'(LAT + 1));
    checkOutput({tag, " strayErr"}, {31'd0, strayErr}, 32'd0);
    checkOutput({tag, " err"}, {31'd0, gotErr}, {31'd0, expErr});
    checkOutput({tag, " rd_data"}, gotRd, expRd);
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [8:0] a,
                              input logic [2:0] f3, input logic [31:0] wd,
                              input logic e, input logic [31:0] x);
    vec_t v;
    v.rdI = r; v.wrI = w; v.addrI = a; v.f3I = f3; v.wdI = wd; v.expErr = e; v.expRd = x;
    return v;
  endfunction

  // Reference model: byte-granular memory, size/sign derived from funct3.
  task automatic modelAccess(input logic rdI, input logic wrI, input logic [8:0] a,
                             input logic [2:0] f3, input logic [31:0] wd, output logic expErr);
    int size;
    logic bad;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    bad = (size == 0) || (wrI && f3[2]) || ((size != 0) && ((int'(a) % size) != 0));
    expErr = bad || (rdI && wrI);
    if (bad) begin
      refRd = 32'h0;
    end else if (wrI) begin
      for (int i = 0; i < size; i++) refMem[int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(refMem[int'(a) + i]) << (8 * i));
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
      refRd = v;
    end
  endtask

  initial begin
    logic expErr;
    logic [2:0] f3Pool [12];
    logic rI, wI;
    logic [8:0] aI;
    logic [2:0] fI;
    logic [31:0] dI;
    int pick;

    rd = 1'b0; wr = 1'b0; addr = '0; funct3 = '0; wr_data = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset err", {31'd0, err}, 32'd0);
    checkOutput("reset rd_data", rd_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    vecs.push_back(mk(0, 1, 9'h010, 3'b010, 32'hDEADBEEF, 0, 32'h00000000));
    vecs.push_back(mk(1, 0, 9'h010, 3'b010, 32'h0,        0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 9'h013, 3'b000, 32'h0,        0, 32'hFFFFFFDE));
    vecs.push_back(mk(1, 0, 9'h013, 3'b100, 32'h0,        0, 32'h000000DE));
    vecs.push_back(mk(1, 0, 9'h012, 3'b001, 32'h0,        0, 32'hFFFFDEAD));
    vecs.push_back(mk(1, 0, 9'h010, 3'b101, 32'h0,        0, 32'h0000BEEF));
    vecs.push_back(mk(0, 1, 9'h011, 3'b000, 32'h000000AA, 0, 32'h0000BEEF));
    vecs.push_back(mk(1, 0, 9'h010, 3'b010, 32'h0,        0, 32'hDEADAAEF));
    vecs.push_back(mk(0, 1, 9'h012, 3'b001, 32'h00001234, 0, 32'hDEADAAEF));
    vecs.push_back(mk(1, 0, 9'h010, 3'b010, 32'h0,        0, 32'h1234AAEF));
    vecs.push_back(mk(1, 0, 9'h006, 3'b010, 32'h0,        1, 32'h00000000));
    vecs.push_back(mk(1, 0, 9'h010, 3'b010, 32'h0,        0, 32'h1234AAEF));
    vecs.push_back(mk(0, 1, 9'h011, 3'b001, 32'h0000FFFF, 1, 32'h00000000));
    vecs.push_back(mk(1, 0, 9'h010, 3'b010, 32'h0,        0, 32'h1234AAEF));
    vecs.push_back(mk(1, 1, 9'h030, 3'b010, 32'hCAFEF00D, 1, 32'h1234AAEF));
    vecs.push_back(mk(1, 0, 9'h030, 3'b010, 32'h0,        0, 32'hCAFEF00D));
    vecs.push_back(mk(0, 1, 9'h040, 3'b010, 32'h11111111, 0, 32'hCAFEF00D));
    vecs.push_back(mk(0, 1, 9'h040, 3'b100, 32'h22222222, 1, 32'h00000000));
    vecs.push_back(mk(1, 0, 9'h040, 3'b010, 32'h0,        0, 32'h11111111));
    vecs.push_back(mk(1, 0, 9'h040, 3'b011, 32'h0,        1, 32'h00000000));
    vecs.push_back(mk(0, 1, 9'h020, 3'b010, 32'h0BADCAFE, 0, 32'h00000000));
    vecs.push_back(mk(1, 0, 9'h020, 3'b010, 32'h0,        0, 32'h0BADCAFE));

    foreach (vecs[i]) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].rdI, vecs[i].wrI, vecs[i].addrI,
                  vecs[i].f3I, vecs[i].wdI, vecs[i].expErr, vecs[i].expRd);
    end

    // Reset during the first BUSY cycle must abort the store.
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; addr = 9'h020; funct3 = 3'b010; wr_data = 32'h12345678;
    @(negedge clk);
    reset = 1'b0; wr = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("abort stall", {31'd0, stall}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort rd_data", rd_data, 32'h0);
    reset = 1'b1;
    runAndCheck("abort reload", 1'b1, 1'b0, 9'h020, 3'b010, 32'h0, 1'b0, 32'h0BADCAFE);
    refRd = 32'h0BADCAFE;

    // Randomized phase confined to a pre-filled window 0x100..0x13F.
    for (int w = 0; w < 16; w++) begin
      dI = $urandom;
      aI = 9'(9'h100 + 4 * w);
      modelAccess(1'b0, 1'b1, aI, 3'b010, dI, expErr);
      runAndCheck("fill", 1'b0, 1'b1, aI, 3'b010, dI, expErr, refRd);
    end

    f3Pool = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000,
               3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
    for (int n = 0; n < 200; n++) begin
      pick = int'($urandom_range(0, 9));
      rI = (pick == 0) || (pick >= 5);
      wI = (pick <= 4);
      aI = 9'(9'h100 + $urandom_range(0, 63));
      fI = f3Pool[$urandom_range(0, 11)];
      dI = $urandom;
      modelAccess(rI, wI, aI, fI, dI, expErr);
      runAndCheck($sformatf("rand%0d", n), rI, wI, aI, fI, dI, expErr, refRd);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1;
        checkOutput("idle stall", {31'd0, stall}, 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
